// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch port.
//   req   : fetch request, held high for the whole FETCH phase
//   addr  : 64-bit byte address of the instruction (the current PC)
//   ready : memory drives rdata valid in this cycle
//   rdata : 32-bit instruction word
// master = fetch stage, slave = instruction memory.
interface instr_fetch_if;
  logic        req;
  logic [63:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch / next-PC stage in front of a single-cycle datapath.
// Owns the PC and the latched NZVC flags. It fetches one instruction over
// the imem port, presents it with its decoded fields for exactly one execute
// phase, then resolves B / BL / BR / CBZ / B.cond and moves the PC.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   imem (master)         req/addr out, ready/rdata in
//   instr, instr_valid    captured word; datapath executes it while valid
//   Rd Rn Rm Imm9..Imm26  combinational field slices of instr
//   pc                    current PC (also the BL link value)
//   br_uncond/br_cond/br_cbz/br_reg, alu_zero, reg_target
//                         branch controls from the datapath
//   set_flags, flags_in   flag update request and new {N,Z,V,C}
//   flags                 latched {N,Z,V,C}
//   stall                 hold the current instruction in execute
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                clk,
  input  logic                reset_n,
  instr_fetch_if.master       imem,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic [4:0]          Rd,
  output logic [4:0]          Rn,
  output logic [4:0]          Rm,
  output logic [8:0]          Imm9,
  output logic [11:0]         Imm12,
  output logic [18:0]         Imm19,
  output logic [25:0]         Imm26,
  output logic [63:0]         pc,
  input  logic                br_uncond,
  input  logic                br_cond,
  input  logic                br_cbz,
  input  logic                br_reg,
  input  logic                alu_zero,
  input  logic [63:0]         reg_target,
  input  logic                set_flags,
  input  logic [3:0]          flags_in,
  output logic [3:0]          flags,
  input  logic                stall
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t             state;
  logic               req_q;
  logic signed [63:0] off26;
  logic signed [63:0] off19;
  logic [63:0]        next_pc;

  // Condition evaluation for B.cond against the latched flags.
  // Codes not listed here are treated as never taken.
  function automatic logic cond_true(input logic [3:0] cond,
                                     input logic n, input logic z,
                                     input logic v);
    case (cond)
      4'b0000: return z;
      4'b0001: return !z;
      4'b1010: return (n == v);
      4'b1011: return (n != v);
      4'b1100: return !z && (n == v);
      4'b1101: return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  assign Rd    = instr[4:0];
  assign Rn    = instr[9:5];
  assign Rm    = instr[20:16];
  assign Imm9  = instr[20:12];
  assign Imm12 = instr[21:10];
  assign Imm19 = instr[23:5];
  assign Imm26 = instr[25:0];

  assign imem.req  = req_q;
  assign imem.addr = pc;

  // Word offsets sign-extended and scaled to bytes.
  assign off26 = {{36{Imm26[25]}}, Imm26, 2'b00};
  assign off19 = {{43{Imm19[18]}}, Imm19, 2'b00};

  // Branch priority: BR > B/BL > CBZ > B.cond > sequential. All adds wrap.
  always_comb begin
    next_pc = pc + 64'd4;
    if (br_reg)
      next_pc = reg_target & ~64'h3;
    else if (br_uncond)
      next_pc = pc + $unsigned(off26);
    else if (br_cbz && alu_zero)
      next_pc = pc + $unsigned(off19);
    else if (br_cond && cond_true(instr[3:0], flags[3], flags[2], flags[1]))
      next_pc = pc + $unsigned(off19);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      flags       <= 4'b0000;
      instr       <= 32'h0;
      req_q       <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
          req_q <= 1'b1;
        end
        // Fetch phase: wait for imem, capture the word into instr.
        S_FETCH: begin
          if (imem.ready) begin
            instr       <= imem.rdata;
            state       <= S_EXEC;
            req_q       <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        // Execute phase: the datapath consumes instr; commit PC and flags
        // on the first non-stalled edge.
        S_EXEC: begin
          if (!stall) begin
            pc          <= next_pc;
            if (set_flags)
              flags <= flags_in;
            state       <= S_FETCH;
            req_q       <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          req_q       <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, imem wait states,
// every branch kind, flag latching, stall hold, wrap-around and reset.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic [4:0]  Rd, Rn, Rm;
  logic [8:0]  Imm9;
  logic [11:0] Imm12;
  logic [18:0] Imm19;
  logic [25:0] Imm26;
  logic [63:0] pc;
  logic        br_uncond, br_cond, br_cbz, br_reg, alu_zero;
  logic [63:0] reg_target;
  logic        set_flags;
  logic [3:0]  flags_in;
  logic [3:0]  flags;
  logic        stall;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] NOP = 32'hD503201F;

  instr_fetch_if imem ();

  instr_fetch #(.RESET_PC(64'h0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem       (imem),
    .instr      (instr),
    .instr_valid(instr_valid),
    .Rd         (Rd),
    .Rn         (Rn),
    .Rm         (Rm),
    .Imm9       (Imm9),
    .Imm12      (Imm12),
    .Imm19      (Imm19),
    .Imm26      (Imm26),
    .pc         (pc),
    .br_uncond  (br_uncond),
    .br_cond    (br_cond),
    .br_cbz     (br_cbz),
    .br_reg     (br_reg),
    .alu_zero   (alu_zero),
    .reg_target (reg_target),
    .set_flags  (set_flags),
    .flags_in   (flags_in),
    .flags      (flags),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic clear_ctrl();
    br_uncond  = 1'b0;
    br_cond    = 1'b0;
    br_cbz     = 1'b0;
    br_reg     = 1'b0;
    alu_zero   = 1'b0;
    reg_target = 64'h0;
    set_flags  = 1'b0;
    flags_in   = 4'h0;
    stall      = 1'b0;
  endtask

  // Check reset values, release reset, step IDLE -> FETCH.
  task automatic reset_release();
    check("rst_req",   imem.req,    0);
    check("rst_valid", instr_valid, 0);
    check("rst_pc",    pc,          64'h0);
    check("rst_flags", flags,       0);
    check("rst_instr", instr,       0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_to_fetch_req",  imem.req,  1);
    check("idle_to_fetch_addr", imem.addr, 64'h0);
  endtask

  // Entered 1 time unit after an edge with the DUT in FETCH. Leaves
  // 1 time unit after the capture edge (DUT in EXEC).
  task automatic fetch(input logic [31:0] word, input int waits,
                       input logic [63:0] addr);
    for (int i = 0; i < waits; i++) begin
      imem.ready = 1'b0;
      imem.rdata = 32'hDEADBEEF;
      @(negedge clk);
      check("wait_req",   imem.req,    1);
      check("wait_addr",  imem.addr,   addr);
      check("wait_valid", instr_valid, 0);
      @(posedge clk); #1;
    end
    imem.ready = 1'b1;
    imem.rdata = word;
    @(negedge clk);
    check("fetch_req",   imem.req,    1);
    check("fetch_addr",  imem.addr,   addr);
    check("fetch_valid", instr_valid, 0);
    @(posedge clk); #1;
    imem.ready = 1'b0;
    imem.rdata = 32'hDEADBEEF;
    check("exec_valid", instr_valid, 1);
    check("exec_req",   imem.req,    0);
    check("exec_instr", instr,       word);
  endtask

  // Branch controls are set by the caller before this task.
  task automatic exec(input int stalls, input logic [63:0] cur_pc,
                      input logic [63:0] exp_pc, input logic [3:0] exp_flags);
    for (int i = 0; i < stalls; i++) begin
      stall = 1'b1;
      @(posedge clk); #1;
      check("stall_valid", instr_valid, 1);
      check("stall_pc",    pc,          cur_pc);
      check("stall_req",   imem.req,    0);
    end
    stall = 1'b0;
    @(posedge clk); #1;
    clear_ctrl();
    check("next_pc",    pc,          exp_pc);
    check("next_addr",  imem.addr,   exp_pc);
    check("next_req",   imem.req,    1);
    check("next_valid", instr_valid, 0);
    check("next_flags", flags,       exp_flags);
  endtask

  initial begin
    reset_n    = 1'b0;
    imem.ready = 1'b0;
    imem.rdata = 32'h0;
    clear_ctrl();
    repeat (2) @(posedge clk);
    #1;
    reset_release();

    // Sequential NOP stream, one instruction every 2 cycles.
    fetch(NOP, 0, 64'h0);
    exec(0, 64'h0, 64'h4, 4'h0);

    // Field decode; also latch N=1,V=0.
    fetch(32'hAAAA5555, 0, 64'h4);
    check("Rd",    Rd,    5'h15);
    check("Rn",    Rn,    5'h0A);
    check("Rm",    Rm,    5'h0A);
    check("Imm9",  Imm9,  9'h0A5);
    check("Imm12", Imm12, 12'hA95);
    check("Imm19", Imm19, 19'h552AA);
    check("Imm26", Imm26, 26'h2AA5555);
    set_flags = 1'b1; flags_in = 4'b1000;
    exec(0, 64'h4, 64'h8, 4'b1000);

    // B.LT Imm19=4 after 3 imem wait cycles: taken.
    fetch(32'h5400008B, 3, 64'h8);
    br_cond = 1'b1;
    exec(0, 64'h8, 64'd24, 4'b1000);

    // B.GE Imm19=4: not taken.
    fetch(32'h5400008A, 0, 64'd24);
    br_cond = 1'b1;
    exec(0, 64'd24, 64'd28, 4'b1000);

    // CBZ Imm19=2 not zero, then zero.
    fetch(32'hB4000040, 0, 64'd28);
    br_cbz = 1'b1; alu_zero = 1'b0;
    exec(0, 64'd28, 64'd32, 4'b1000);
    fetch(32'hB4000040, 0, 64'd32);
    br_cbz = 1'b1; alu_zero = 1'b1;
    exec(0, 64'd32, 64'd40, 4'b1000);

    // BR with a 3-cycle stall; br_uncond also asserted, BR must win.
    fetch(32'hD61F0000, 0, 64'd40);
    br_reg = 1'b1; reg_target = 64'h103; br_uncond = 1'b1;
    exec(3, 64'd40, 64'h100, 4'b1000);

    // B.EQ with Z=0: not taken.
    fetch(32'h54000080, 0, 64'h100);
    br_cond = 1'b1;
    exec(0, 64'h100, 64'h104, 4'b1000);

    // B Imm26=3 with CBZ and B.cond also asserted: B wins.
    fetch(32'h14000003, 0, 64'h104);
    br_uncond = 1'b1; br_cbz = 1'b1; alu_zero = 1'b1; br_cond = 1'b1;
    exec(0, 64'h104, 64'h110, 4'b1000);

    // B.EQ uses latched flags (Z=0), not flags_in being set now.
    fetch(32'h54000080, 0, 64'h110);
    br_cond = 1'b1; set_flags = 1'b1; flags_in = 4'b0100;
    exec(0, 64'h110, 64'h114, 4'b0100);

    // Same B.EQ now sees Z=1: taken.
    fetch(32'h54000080, 0, 64'h114);
    br_cond = 1'b1;
    exec(0, 64'h114, 64'h124, 4'b0100);

    // B.LE with Z=1: taken.
    fetch(32'h5400008D, 0, 64'h124);
    br_cond = 1'b1;
    exec(0, 64'h124, 64'h134, 4'b0100);

    // Reset asserted mid-FETCH takes effect without a clock edge.
    imem.ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    reset_release();

    // B with Imm26 = -1 at pc 0 wraps, then pc+4 wraps back to 0.
    fetch(32'h17FFFFFF, 0, 64'h0);
    br_uncond = 1'b1;
    exec(0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 4'h0);
    fetch(NOP, 0, 64'hFFFF_FFFF_FFFF_FFFC);
    exec(0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
